fifo_uart_tx: RTL and testbench

Single-clock serializer that drains the read port of the team's 3-bit FIFO and transmits each word as an asynchronous serial (UART-style) frame on one pin. It sits on the read-clock side of the FIFO: it watches `empty`, pulses `re`, captures `rdata`, and shifts the word out LSB-first. It is paced by a programmable clocks-per-bit divider and gated by an active-low clear-to-send input.

---
 rtl/fifo_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the read port of a FIFO and sends each word as an
// asynchronous serial frame (start, LSB-first data, optional parity, stop)
// on txd.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int WIDTH        = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  output logic             re,
  input  logic [WIDTH-1:0] rdata,
  input  logic             cts_n,
  output logic             txd,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // Even parity of a data word: the XOR of all its bits.
  function automatic logic parity_even(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic par_r;
  logic par_s;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd5
  } state_t;
`endif

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   clk_cnt_r;
  logic [CW-1:0]   clk_cnt_s;
  logic [BW-1:0]   bit_cnt_r;
  logic [BW-1:0]   bit_cnt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic            txd_r;
  logic            txd_s;
  logic            busy_r;
  logic            re_s;
  logic            clk_done_s;

  // Next-state, counter, shift register and next txd computation.
  always_comb begin
    state_s    = state_r;
    clk_cnt_s  = clk_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shreg_s    = shreg_r;
    re_s       = 1'b0;
    txd_s      = 1'b1;
    clk_done_s = (clk_cnt_r == CLK_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
    par_s      = par_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (!empty && !cts_n) begin
          re_s    = 1'b1;
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        shreg_s   = rdata;
        clk_cnt_s = '0;
        bit_cnt_s = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_s     = parity_even(rdata);
`endif
        state_s   = S_START;
      end
      S_START: begin
        if (clk_done_s) begin
          clk_cnt_s = '0;
          state_s   = S_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_done_s) begin
          clk_cnt_s = '0;
          shreg_s   = shreg_r >> 1;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_s   = S_PARITY;
`else
            state_s   = S_STOP;
`endif
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (clk_done_s) begin
          clk_cnt_s = '0;
          state_s   = S_STOP;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (clk_done_s) begin
          clk_cnt_s = '0;
          state_s   = S_IDLE;
        end else begin
          clk_cnt_s = clk_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // txd is registered from the upcoming state so the line level lines up
    // with the state that owns it.
    case (state_s)
      S_START:  txd_s = 1'b0;
      S_DATA:   txd_s = shreg_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: txd_s = par_s;
`endif
      default:  txd_s = 1'b1;
    endcase
  end

  // State register plus datapath registers; reset returns to an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      clk_cnt_r <= '0;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shreg_r   <= shreg_s;
      txd_r     <= txd_s;
      busy_r    <= (state_s != S_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

  // re is gated by rst_n so no FIFO read can happen while reset is held.
  assign re   = re_s && rst_n;
  assign txd  = txd_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model on the read side, frame
// monitor on txd, scoreboard of expected words.
module tb_fifo_uart_tx;

  localparam int W   = 3;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = (2 + W + P) * CPB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         empty;
  logic         re;
  logic [W-1:0] rdata;
  logic         cts_n;
  logic         txd;
  logic         busy;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .empty (empty),
    .re    (re),
    .rdata (rdata),
    .cts_n (cts_n),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  int re_cnt     = 0;
  int start_cnt  = 0;
  int busy_cnt   = 0;
  int low_cnt    = 0;
  int high_run   = 0;
  int last_gap   = 0;
  int frame_no   = 0;
  int mon_idx    = 0;
  logic mon_active = 1'b0;
  logic frame_bits [FL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Compare a captured frame against the next scoreboard word.
  task automatic check_frame();
    logic [W-1:0] w;
    logic expb;
    int b;
    check_eq($sformatf("frame%0d_expected", frame_no), (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      for (int i = 0; i < FL; i++) begin
        b = i / CPB;
        if (b == 0) expb = 1'b0;
        else if (b <= W) expb = w[b-1];
        else if (P == 1 && b == W + 1) expb = ^w;
        else expb = 1'b1;
        check_eq($sformatf("frame%0d_cyc%0d", frame_no, i), frame_bits[i], expb);
      end
    end
    frame_no++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    tick();
    while (!(exp_q.size() == 0 && !busy && !mon_active) && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_start(input int s0, input int budget, input string tag);
    int n = 0;
    while (start_cnt == s0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, (n < budget) ? 1 : 0, 1);
  endtask

  // FIFO model: registered read data, empty updated at each clock edge.
  initial begin
    empty = 1'b1;
    rdata = '0;
    forever begin
      @(posedge clk);
      if (re) begin
        re_cnt++;
        check_eq("re_while_empty", empty, 1'b0);
        if (fifo_q.size() != 0) rdata <= fifo_q.pop_front();
      end
      empty <= (fifo_q.size() == 0);
    end
  end

  // Frame monitor: captures txd sample-per-cycle after each start edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (mon_active && exp_q.size() > 0) void'(exp_q.pop_front());
        mon_active = 1'b0;
        high_run   = 0;
      end else begin
        if (busy) busy_cnt++;
        if (!txd) low_cnt++;
        if (!mon_active) begin
          if (!txd) begin
            mon_active    = 1'b1;
            frame_bits[0] = txd;
            mon_idx       = 1;
            last_gap      = high_run;
            high_run      = 0;
            start_cnt++;
          end else begin
            high_run++;
          end
        end else begin
          frame_bits[mon_idx] = txd;
          mon_idx++;
          if (mon_idx == FL) begin
            mon_active = 1'b0;
            check_frame();
          end
        end
      end
    end
  end

  initial begin
    int r0;
    int s0;
    int b0;
    int l0;
    int n;

    // Reset held with a non-empty FIFO.
    rst_n = 1'b0;
    cts_n = 1'b0;
    fifo_q.push_back(3'b111);
    repeat (3) tick();
    check_eq("reset_txd", txd, 1'b1);
    check_eq("reset_re", re, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    fifo_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    l0 = low_cnt;
    repeat (50) tick();
    check_eq("idle_no_re", re_cnt, 0);
    check_eq("idle_txd_high", low_cnt - l0, 0);

    // Single word with T+2 start latency and busy length.
    b0 = busy_cnt;
    r0 = re_cnt;
    push_word(3'b101);
    n = 0;
    while (!re && n < 20) begin
      tick();
      n++;
    end
    check_eq("single_re_seen", (n < 20) ? 1 : 0, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (txd && n < 10);
    check_eq("single_start_latency", n, 2);
    wait_idle(100, "single_done");
    check_eq("single_re_count", re_cnt - r0, 1);
    check_eq("single_busy_cycles", busy_cnt - b0, 21);

    // Back-to-back words: minimum gap after the stop bit.
    r0 = re_cnt;
    s0 = start_cnt;
    push_word(3'b001);
    push_word(3'b110);
    wait_start(s0, 50, "b2b_first_start");
    wait_start(s0 + 1, 100, "b2b_second_start");
    check_eq("b2b_gap", last_gap, 2);
    wait_idle(100, "b2b_done");
    check_eq("b2b_re_count", re_cnt - r0, 2);

    // Flow control: cts_n high blocks new frames.
    cts_n = 1'b1;
    r0 = re_cnt;
    l0 = low_cnt;
    push_word(3'b011);
    repeat (40) tick();
    check_eq("cts_no_re", re_cnt - r0, 0);
    check_eq("cts_txd_high", low_cnt - l0, 0);
    cts_n = 1'b0;
    s0 = start_cnt;
    wait_start(s0, 20, "cts_start");
    repeat (5) tick();
    cts_n = 1'b1;
    wait_idle(100, "cts_midframe_done");
    check_eq("cts_re_count", re_cnt - r0, 1);
    cts_n = 1'b0;

    // Parity words (parity bit checked by the monitor when enabled).
    push_word(3'b110);
    push_word(3'b111);
    wait_idle(200, "parity_done");

    // Reset during the second data bit.
    s0 = start_cnt;
    push_word(3'b101);
    wait_start(s0, 20, "rst_mid_start");
    repeat (8) tick();
    check_eq("rst_mid_bit1_low", txd, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_txd", txd, 1'b1);
    check_eq("rst_mid_re", re, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_mid_discarded", exp_q.size(), 0);
    r0 = re_cnt;
    s0 = start_cnt;
    push_word(3'b100);
    wait_start(s0, 20, "rst_after_start");
    check_eq("rst_after_re_first", re_cnt - r0, 1);
    wait_idle(100, "rst_after_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit in case a wait loop is broken.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
